// File: rtl/m_lsfr_pkg.sv
// Shared constants, response codes and write-FSM states
// for the AXI4-Lite LFSR slave.
package m_lsfr_pkg;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_SEED  = 2'd1;
  localparam logic [1:0] REG_TAPS  = 2'd2;
  localparam logic [1:0] REG_STATE = 2'd3;

  localparam logic [31:0] SEED_RST  = 32'h0000_0001;
  localparam logic [31:0] TAPS_RST  = 32'h8020_0003;
  localparam logic [31:0] STATE_RST = 32'h0000_0001;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wstate_t;

  function automatic logic [31:0] strb_merge(
    input logic [31:0] old,
    input logic [31:0] data,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR with seed load; load beats step and
// a zero seed is replaced by 1 to avoid lockup.
module lfsr_core
  import m_lsfr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic [31:0] taps,
  output logic [31:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= STATE_RST;
    else if (load)
      state <= (seed == '0) ? 32'h0000_0001 : seed;
    else if (enable)
      state <= {state[30:0], ^(state & taps)};
  end

endmodule

// File: rtl/m_lsfr_axil_slave.sv
// AXI4-Lite register slave wrapping an LFSR: CTRL, SEED,
// TAPS and read-only STATE.
module m_lsfr_axil_slave
  import m_lsfr_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [31:0]                     lfsr_out
);

  wstate_t     state_q, state_d;
  logic        rdy_en;
  logic        aw_hs, w_hs, ar_hs, wr_en;
  logic [1:0]  awidx_q, wr_idx;
  logic [31:0] wdata_q, wr_data;
  logic [3:0]  wstrb_q, wr_strb;
  logic        enable_q, load_q;
  logic [31:0] seed_q, taps_q, lfsr_state;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q, rd_mux;
  logic        rvalid_q;
  logic        unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Keeps READYs low while reset is held and for its release edge.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
  assign wr_en = (aw_hs | (state_q == W_HAVE_AW)) &
                 (w_hs  | (state_q == W_HAVE_W));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= W_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      W_IDLE: begin
        if (wr_en)      state_d = W_RESP;
        else if (aw_hs) state_d = W_HAVE_AW;
        else if (w_hs)  state_d = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)  state_d = W_RESP;
      W_HAVE_W:  if (aw_hs) state_d = W_RESP;
      W_RESP:    if (S_AXI_BREADY) state_d = W_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY = rdy_en &
      ((state_q == W_IDLE) | (state_q == W_HAVE_W));
    S_AXI_WREADY  = rdy_en &
      ((state_q == W_IDLE) | (state_q == W_HAVE_AW));
    S_AXI_BVALID  = (state_q == W_RESP);
  end

  assign wr_idx  = (state_q == W_HAVE_AW) ? awidx_q : S_AXI_AWADDR[3:2];
  assign wr_data = (state_q == W_HAVE_W)  ? wdata_q : S_AXI_WDATA;
  assign wr_strb = (state_q == W_HAVE_W)  ? wstrb_q : S_AXI_WSTRB;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      awidx_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      enable_q <= 1'b0;
      load_q   <= 1'b0;
      seed_q   <= SEED_RST;
      taps_q   <= TAPS_RST;
      bresp_q  <= RESP_OKAY;
    end else begin
      load_q <= 1'b0;
      if (aw_hs) awidx_q <= S_AXI_AWADDR[3:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (wr_en) begin
        bresp_q <= RESP_OKAY;
        unique case (wr_idx)
          REG_CTRL: if (wr_strb[0]) begin
            enable_q <= wr_data[0];
            load_q   <= wr_data[1];
          end
          REG_SEED:  seed_q  <= strb_merge(seed_q, wr_data, wr_strb);
          REG_TAPS:  taps_q  <= strb_merge(taps_q, wr_data, wr_strb);
          REG_STATE: bresp_q <= RESP_SLVERR;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (S_AXI_ARADDR[3:2])
      REG_CTRL:  rd_mux = {31'd0, enable_q};
      REG_SEED:  rd_mux = seed_q;
      REG_TAPS:  rd_mux = taps_q;
      REG_STATE: rd_mux = lfsr_state;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
    end else if (ar_hs) begin
      rdata_q  <= rd_mux;
      rresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b1;
    end else if (S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign S_AXI_ARREADY = rdy_en & ~rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign lfsr_out      = lfsr_state;

  lfsr_core u_core (
    .clk    (ACLK),
    .rst    (ARESET),
    .enable (enable_q),
    .load   (load_q),
    .seed   (seed_q),
    .taps   (taps_q),
    .state  (lfsr_state)
  );

endmodule

// File: tb/tb_m_lsfr_axil_slave.sv
// Bench for m_lsfr_axil_slave: directed cases plus random
// register traffic against a register-level model.
module tb_m_lsfr_axil_slave;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        bready = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, lfsr_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wr_edge = 0;

  logic        m_en;
  logic [31:0] m_seed, m_taps, m_state;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  m_lsfr_axil_slave dut (
    .ACLK          (clk),
    .ARESET        (areset),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .lfsr_out      (lfsr_out)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_step(input logic [31:0] s,
                                             input logic [31:0] t);
    logic [31:0] r;
    r = s << 1;
    r[0] = ($countones(s & t) % 2) == 1;
    return r;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++)
      if (s[i]) mask = mask | (32'hFF << (8 * i));
    return (old & ~mask) | (d & mask);
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return {31'd0, m_en};
      2'd1:    return m_seed;
      2'd2:    return m_taps;
      default: return m_state;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 1'b0;
    m_seed = 32'h0000_0001;
    m_taps = 32'h8020_0003;
    m_state = 32'h0000_0001;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    bit aw_d, w_d, got;
    int n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    aw_d = 0; w_d = 0; got = 0; n = 0; resp = 2'b11;
    while (!(aw_d && w_d) && n < 50) begin
      @(negedge clk);
      if (awvalid && awready) begin aw_d = 1; wr_edge = cyc + 1; end
      if (wvalid && wready) begin w_d = 1; wr_edge = cyc + 1; end
      @(posedge clk); #1;
      if (aw_d) awvalid = 1'b0;
      if (w_d) wvalid = 1'b0;
      n++;
    end
    n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      if (bvalid) begin resp = bresp; got = 1; end
      @(posedge clk); #1;
      n++;
    end
    bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_d && w_d && got)) check("wr_timeout", 0, 1);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    bit ar_d, got;
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    ar_d = 0; got = 0; n = 0; d = 'x; resp = 2'b11;
    while (!ar_d && n < 50) begin
      @(negedge clk);
      if (arready) ar_d = 1;
      @(posedge clk); #1;
      if (ar_d) arvalid = 1'b0;
      n++;
    end
    n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      if (rvalid) begin d = rdata; resp = rresp; got = 1; end
      @(posedge clk); #1;
      n++;
    end
    rready = 1'b0; arvalid = 1'b0;
    if (!(ar_d && got)) check("rd_timeout", 0, 1);
  endtask

  task automatic read_check(input string tag, input logic [3:0] a);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    check(tag, d, model_read(a));
    check({tag, "_rresp"}, {30'd0, r}, 32'd0);
  endtask

  task automatic write_check(input string tag, input logic [3:0] a,
                             input logic [31:0] d, input logic [3:0] s);
    logic [1:0] r;
    axi_write(a, d, s, r);
    check({tag, "_bresp"}, {30'd0, r},
          (a[3:2] == 2'd3) ? 32'd2 : 32'd0);
    case (a[3:2])
      2'd0: if (s[0]) begin
        m_en = d[0];
        if (d[1]) m_state = (m_seed == 0) ? 32'd1 : m_seed;
      end
      2'd1: m_seed = byte_merge(m_seed, d, s);
      2'd2: m_taps = byte_merge(m_taps, d, s);
      default: ;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d0, d1, exp;
    logic [1:0]  r0, r1;
    int we, steps;

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
    check("rst_valid", {30'd0, bvalid, rvalid}, 32'd0);
    check("rst_resp", {28'd0, bresp, rresp}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_lfsr", lfsr_out, 32'h0000_0001);
    @(posedge clk); #1;
    areset = 1'b0;
    @(negedge clk);
    check("rel_ready_low", {29'd0, awready, wready, arready}, 32'd0);
    @(negedge clk);
    check("rel_ready_high", {29'd0, awready, wready, arready}, 32'd7);
    @(posedge clk); #1;

    foreach (d0[i]) if (i < 4) read_check("rst_reg", 4'(i * 4));

    write_check("seed2", 4'h4, 32'h2, 4'hF);
    write_check("tapsB", 4'h8, 32'hB, 4'hF);
    read_check("rd_seed2", 4'h4);
    read_check("rd_tapsB", 4'h8);

    write_check("wr_state", 4'hC, 32'h5, 4'hF);
    read_check("rd_state", 4'hC);

    write_check("seed1", 4'h4, 32'h1, 4'hF);
    write_check("taps_def", 4'h8, 32'h8020_0003, 4'hF);
    write_check("ctrl3", 4'h0, 32'h3, 4'hF);
    we = wr_edge;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      steps = cyc - we - 1;
      exp = m_seed;
      for (int j = 0; j < steps; j++) exp = model_step(exp, m_taps);
      check("lfsr_seq", lfsr_out, exp);
    end
    @(posedge clk); #1;
    write_check("ctrl0", 4'h0, 32'h0, 4'hF);
    steps = wr_edge - we - 1;
    m_state = m_seed;
    for (int j = 0; j < steps; j++) m_state = model_step(m_state, m_taps);
    read_check("rd_state_stop", 4'hC);
    @(negedge clk);
    check("lfsr_stop", lfsr_out, m_state);
    @(posedge clk); #1;

    write_check("seed0", 4'h4, 32'h0, 4'hF);
    write_check("load0", 4'h0, 32'h2, 4'h1);
    read_check("rd_zero_guard", 4'hC);

    write_check("seed_s", 4'h4, 32'h1, 4'hF);
    write_check("strb", 4'h4, 32'hAABB_CCDD, 4'b0010);
    read_check("rd_strb", 4'h4);
    check("strb_val", m_seed, 32'h0000_CC01);
    write_check("strb0", 4'h8, 32'hFFFF_FFFF, 4'b0000);
    read_check("rd_strb0", 4'h8);

    fork
      axi_write(4'h4, 32'h1234_5678, 4'hF, r0);
      axi_read(4'h4, d1, r1);
    join
    check("rw_same_cycle", d1, m_seed);
    check("rw_bresp", {30'd0, r0}, 32'd0);
    m_seed = 32'h1234_5678;
    read_check("rd_after_rw", 4'h4);

    wdata = 32'hDEAD_0001; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    check("w_first_rdy", {31'd0, wready}, 32'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    awaddr = 4'h4; awvalid = 1'b1;
    @(negedge clk);
    check("aw_late_rdy", {31'd0, awready}, 32'd1);
    @(posedge clk); #1;
    awaddr = 4'h8; wdata = 32'h0BAD_0BAD;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bhold", {27'd0, bvalid, awready, wready, bresp}, 32'h10);
      @(posedge clk); #1;
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    check("bvalid_at_ready", {31'd0, bvalid}, 32'd1);
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    check("bvalid_drop", {31'd0, bvalid}, 32'd0);
    @(posedge clk); #1;
    m_seed = 32'hDEAD_0001;
    read_check("rd_slow_w", 4'h4);
    read_check("rd_no_second", 4'h8);

    for (int k = 0; k < 40; k++) begin
      logic [3:0]  a;
      logic [31:0] d;
      a = 4'($urandom_range(0, 3) * 4);
      d = $urandom;
      if (a == 4'h0) d[0] = 1'b0;
      if ($urandom_range(0, 1) == 1)
        write_check("rnd_wr", a, d, 4'($urandom_range(0, 15)));
      else
        read_check("rnd_rd", a);
    end

    write_check("pre_abort", 4'h0, 32'h1, 4'h1);
    awaddr = 4'h4; awvalid = 1'b1; wdata = 32'h5555_5555;
    @(negedge clk);
    check("abort_aw_rdy", {31'd0, awready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    areset = 1'b1;
    model_reset();
    @(negedge clk);
    check("abort_in_rst", {27'd0, awready, wready, arready, bvalid, rvalid},
          32'd0);
    @(posedge clk); #1;
    areset = 1'b0;
    bready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_b", {31'd0, bvalid}, 32'd0);
    end
    @(posedge clk); #1;
    bready = 1'b0;
    read_check("abort_ctrl", 4'h0);
    read_check("abort_seed", 4'h4);
    read_check("abort_taps", 4'h8);
    read_check("abort_state", 4'hC);
    @(negedge clk);
    check("abort_lfsr", lfsr_out, 32'h0000_0001);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
